// File: rtl/fan_adder_node_pipe_if.sv
// rtl/fan_adder_node_pipe_if.sv - lane bus for the FAN adder node: input/output beats, handshake, sticky error.
// FAN_NODE_STATS_EN adds the merge_cnt/beat_cnt counters to the bus.
interface fan_adder_node_pipe_if #(
    parameter int NUM_IN  = 4,
    parameter int DW_LINE = 136
);
    logic [NUM_IN*DW_LINE-1:0] in;
    logic                      in_valid;
    logic                      in_ready;
    logic [NUM_IN*DW_LINE-1:0] out;
    logic                      out_valid;
    logic                      out_ready;
    logic                      err;
`ifdef FAN_NODE_STATS_EN
    logic [15:0]               merge_cnt;
    logic [15:0]               beat_cnt;

    modport master (
        output in, in_valid, out_ready,
        input  in_ready, out, out_valid, err, merge_cnt, beat_cnt
    );

    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, out, out_valid, err, merge_cnt, beat_cnt
    );
`else
    modport master (
        output in, in_valid, out_ready,
        input  in_ready, out, out_valid, err
    );

    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, out, out_valid, err
    );
`endif
endinterface

// File: rtl/fan_adder_node_pipe.sv
// rtl/fan_adder_node_pipe.sv - pipelined FAN reduction node: merges a left and right operand on a centre lane.
// Optional macro FAN_NODE_STATS_EN adds saturating beat/merge counters.
module fan_adder_node_pipe #(
    parameter int N_STACK  = 4,
    parameter int DW_DATA  = 32,
    parameter int DW_ROW   = 4,
    parameter int DW_CTRL  = 4,
    parameter int DW_LINE  = N_STACK*DW_DATA + DW_ROW + DW_CTRL,
    parameter int NUM_IN   = 4,
    parameter int ADD_LAT  = 1,
    parameter int SYMMETRY = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    fan_adder_node_pipe_if.slave   bus
);
    localparam int HALF      = NUM_IN/2;
    localparam int OUT_LEFT  = NUM_IN/2 - 1;
    localparam int OUT_RIGHT = NUM_IN/2;
    localparam int DW_DAT    = N_STACK*DW_DATA;
    localparam int ROW_LSB   = DW_DAT;
    localparam int CL_BIT    = DW_LINE - DW_CTRL;
    localparam int CR_BIT    = DW_LINE - DW_CTRL + 1;
    localparam int KEEP_BIT  = DW_LINE - 2;
    localparam int VALID_BIT = DW_LINE - 1;

    typedef logic [DW_LINE-1:0]        line_t;
    typedef logic [NUM_IN*DW_LINE-1:0] bus_t;

    line_t             lane_in [NUM_IN];
    logic [NUM_IN-1:0] elig;

    logic [DW_DAT-1:0] l_data, r_data, sum_data;
    logic [DW_ROW-1:0] l_row, r_row;
    logic              l_cl, r_cr;
    logic              l_exist, r_exist, l_multi, r_multi;
    logic              merge, dest_right, dest_keep;
    line_t             res_line;
    bus_t              merged;

    logic              in_ready, accept;
    bus_t              pipe_q [ADD_LAT];
    bus_t              pipe_d [ADD_LAT];
    logic [ADD_LAT-1:0] vld_q, vld_d;
    logic              err_q, err_d;

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            lane_in[i] = bus.in[i*DW_LINE +: DW_LINE];
            elig[i]    = lane_in[i][VALID_BIT] & ~lane_in[i][KEEP_BIT];
        end
    end

    // Operands are the OR of the eligible lanes of each half; more than one is a protocol error.
    always_comb begin
        l_data  = '0;
        l_row   = '0;
        l_cl    = 1'b0;
        l_exist = 1'b0;
        l_multi = 1'b0;
        r_data  = '0;
        r_row   = '0;
        r_cr    = 1'b0;
        r_exist = 1'b0;
        r_multi = 1'b0;
        for (int i = 0; i < HALF; i++) begin
            if (elig[i]) begin
                l_multi = l_multi | l_exist;
                l_exist = 1'b1;
                l_data  = l_data | lane_in[i][DW_DAT-1:0];
                l_row   = l_row  | lane_in[i][ROW_LSB +: DW_ROW];
                l_cl    = l_cl   | lane_in[i][CL_BIT];
            end
        end
        for (int i = HALF; i < NUM_IN; i++) begin
            if (elig[i]) begin
                r_multi = r_multi | r_exist;
                r_exist = 1'b1;
                r_data  = r_data | lane_in[i][DW_DAT-1:0];
                r_row   = r_row  | lane_in[i][ROW_LSB +: DW_ROW];
                r_cr    = r_cr   | lane_in[i][CR_BIT];
            end
        end
    end

    always_comb begin
        merge = l_exist & r_exist & (l_row == r_row);
        for (int k = 0; k < N_STACK; k++) begin
            sum_data[k*DW_DATA +: DW_DATA] = l_data[k*DW_DATA +: DW_DATA] + r_data[k*DW_DATA +: DW_DATA];
        end
        res_line                      = '0;
        res_line[DW_DAT-1:0]          = sum_data;
        res_line[ROW_LSB +: DW_ROW]   = l_row;
        res_line[CL_BIT]              = l_cl;
        res_line[CR_BIT]              = r_cr;
        res_line[KEEP_BIT]            = ~l_cl & ~r_cr;
        res_line[VALID_BIT]           = 1'b1;
        // Both flags set falls to the left; neither flag defers to SYMMETRY.
        dest_right = (r_cr & ~l_cl) | (~r_cr & ~l_cl & (SYMMETRY != 0));
        dest_keep  = dest_right ? (lane_in[OUT_RIGHT][VALID_BIT] & lane_in[OUT_RIGHT][KEEP_BIT])
                                : (lane_in[OUT_LEFT][VALID_BIT]  & lane_in[OUT_LEFT][KEEP_BIT]);
    end

    always_comb begin
        merged = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!merge) begin
                merged[i*DW_LINE +: DW_LINE] = lane_in[i];
            end else if (i == OUT_LEFT) begin
                merged[i*DW_LINE +: DW_LINE] = dest_right ? '0 : res_line;
            end else if (i == OUT_RIGHT) begin
                merged[i*DW_LINE +: DW_LINE] = dest_right ? res_line : '0;
            end else if (elig[i]) begin
                merged[i*DW_LINE +: DW_LINE] = '0;
            end else begin
                merged[i*DW_LINE +: DW_LINE] = lane_in[i];
            end
        end
    end

    // Whole pipe advances or holds as one; bubbles travel as cleared valid bits.
    assign in_ready = ~vld_q[ADD_LAT-1] | bus.out_ready;
    assign accept   = bus.in_valid & in_ready;

    always_comb begin
        pipe_d = pipe_q;
        vld_d  = vld_q;
        if (in_ready) begin
            pipe_d[0] = merged;
            vld_d[0]  = bus.in_valid;
            for (int s = 1; s < ADD_LAT; s++) begin
                pipe_d[s] = pipe_q[s-1];
                vld_d[s]  = vld_q[s-1];
            end
        end
        err_d = err_q | (accept & (l_multi | r_multi | (merge & dest_keep)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < ADD_LAT; s++) begin
                pipe_q[s] <= '0;
            end
            vld_q <= '0;
            err_q <= 1'b0;
        end else begin
            pipe_q <= pipe_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out       = pipe_q[ADD_LAT-1];
    assign bus.out_valid = vld_q[ADD_LAT-1];
    assign bus.err       = err_q;

`ifdef FAN_NODE_STATS_EN
    logic [15:0] beat_cnt_q, beat_cnt_d, merge_cnt_q, merge_cnt_d;

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        merge_cnt_d = merge_cnt_q;
        if (accept && beat_cnt_q != 16'hFFFF) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end
        if (accept && merge && merge_cnt_q != 16'hFFFF) begin
            merge_cnt_d = merge_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            merge_cnt_q <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            merge_cnt_q <= merge_cnt_d;
        end
    end

    assign bus.beat_cnt  = beat_cnt_q;
    assign bus.merge_cnt = merge_cnt_q;
`endif
endmodule

// File: tb/tb_fan_adder_node_pipe.sv
// tb/tb_fan_adder_node_pipe.sv - directed self-checking bench for fan_adder_node_pipe (4-lane and 8-lane builds).
module tb_fan_adder_node_pipe;
    localparam int DW_LINE = 136;
    localparam int NA = 4;
    localparam int NB = 8;

    typedef logic [DW_LINE-1:0]    line_t;
    typedef logic [NA*DW_LINE-1:0] bus_a_t;
    typedef logic [NB*DW_LINE-1:0] bus_b_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fan_adder_node_pipe_if #(.NUM_IN(NA), .DW_LINE(DW_LINE)) bus_a ();
    fan_adder_node_pipe_if #(.NUM_IN(NB), .DW_LINE(DW_LINE)) bus_b ();

    fan_adder_node_pipe #(.NUM_IN(NA), .ADD_LAT(1), .SYMMETRY(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    fan_adder_node_pipe #(.NUM_IN(NB), .ADD_LAT(3), .SYMMETRY(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    function automatic line_t mk(input bit v, input bit kp, input bit cl, input bit cr,
                                 input logic [3:0] row, input logic [31:0] e);
        line_t l = '0;
        for (int k = 0; k < 4; k++) l[k*32 +: 32] = e;
        l[128 +: 4] = row;
        l[132] = cl;
        l[133] = cr;
        l[134] = kp;
        l[135] = v;
        return l;
    endfunction

    function automatic bus_a_t pk4(input line_t l0, input line_t l1, input line_t l2, input line_t l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic bus_b_t beat_b(input int k);
        bus_b_t b = '0;
        logic [3:0] rr = (k % 2 == 1) ? 4'(k + 1) : 4'(k);
        b[0*DW_LINE +: DW_LINE] = mk(0, 0, 0, 0, 4'd0, 32'(k));
        b[3*DW_LINE +: DW_LINE] = mk(1, 0, 0, 0, 4'(k), 32'(k));
        b[4*DW_LINE +: DW_LINE] = mk(1, 0, 0, 0, rr, 32'd100);
        return b;
    endfunction

    function automatic bus_b_t exp_b(input int k);
        bus_b_t b = beat_b(k);
        if (k % 2 == 0) begin
            b[3*DW_LINE +: DW_LINE] = mk(1, 1, 0, 0, 4'(k), 32'(k + 100));
            b[4*DW_LINE +: DW_LINE] = '0;
        end
        return b;
    endfunction

    task automatic drive_a(input bus_a_t v);
        bus_a.in       = v;
        bus_a.in_valid = 1'b1;
        bus_a.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.err !== 1'b0 || bus_a.out !== '0 || bus_a.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_a out_valid=%b err=%b in_ready=%b (need 0 0 1, out 0)", bus_a.out_valid, bus_a.err, bus_a.in_ready);
        end
        checks++;
        if (bus_b.out_valid !== 1'b0 || bus_b.err !== 1'b0 || bus_b.out !== '0) begin
            errors++;
            $display("FAIL reset_b out_valid=%b err=%b (need 0 0, out 0)", bus_b.out_valid, bus_b.err);
        end
    endtask

    task automatic test_merge();
        bus_a_t expv = pk4('0, mk(1, 1, 0, 0, 4'd3, 32'd12), '0, '0);
        drive_a(pk4('0, mk(1, 0, 0, 0, 4'd3, 32'd5), mk(1, 0, 0, 0, 4'd3, 32'd7), '0));
        checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out !== expv) begin
            errors++;
            $display("FAIL merge valid=%b got=%h need=%h", bus_a.out_valid, bus_a.out, expv);
        end
    endtask

    task automatic test_mismatch();
        bus_a_t v = pk4(mk(0, 0, 0, 0, 4'd9, 32'h11), mk(1, 0, 0, 0, 4'd3, 32'd5), mk(1, 0, 0, 0, 4'd4, 32'd7), '0);
        drive_a(v);
        checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out !== v) begin
            errors++;
            $display("FAIL mismatch valid=%b got=%h need=%h", bus_a.out_valid, bus_a.out, v);
        end
    endtask

    task automatic test_wrap_cont();
        line_t  keep0 = mk(1, 1, 0, 0, 4'd7, 32'd9);
        line_t  junk3 = mk(0, 1, 1, 1, 4'd2, 32'hABCD);
        bus_a_t expv  = pk4(keep0, mk(1, 0, 1, 0, 4'd2, 32'd0), '0, junk3);
        drive_a(pk4(keep0, mk(1, 0, 1, 0, 4'd2, 32'hFFFFFFFF), mk(1, 0, 0, 0, 4'd2, 32'd1), junk3));
        checks++;
        if (bus_a.out !== expv) begin
            errors++;
            $display("FAIL wrap_cont got=%h need=%h", bus_a.out, expv);
        end
        checks++;
        if (bus_a.err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_err err=%b need 0", bus_a.err);
        end
    endtask

    task automatic test_cont_right();
        bus_a_t expv = pk4('0, '0, mk(1, 0, 0, 1, 4'd6, 32'd3), '0);
        drive_a(pk4('0, mk(1, 0, 0, 0, 4'd6, 32'd1), mk(1, 0, 0, 1, 4'd6, 32'd2), '0));
        checks++;
        if (bus_a.out !== expv) begin
            errors++;
            $display("FAIL cont_right got=%h need=%h", bus_a.out, expv);
        end
    endtask

    task automatic test_error_reset();
        bus_a_t expv = pk4('0, mk(1, 1, 0, 0, 4'd1, 32'd7), '0, '0);
        drive_a(pk4(mk(1, 0, 0, 0, 4'd1, 32'd1), mk(1, 0, 0, 0, 4'd1, 32'd2), mk(1, 0, 0, 0, 4'd1, 32'd4), '0));
        checks++;
        if (bus_a.err !== 1'b1 || bus_a.out !== expv) begin
            errors++;
            $display("FAIL multi_err err=%b got=%h need=%h", bus_a.err, bus_a.out, expv);
        end
        drive_a(pk4('0, mk(1, 0, 0, 0, 4'd3, 32'd5), mk(1, 0, 0, 0, 4'd3, 32'd7), '0));
        checks++;
        if (bus_a.err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky err=%b need 1", bus_a.err);
        end
        rst = 1'b1;
        bus_a.in = pk4('0, mk(1, 0, 0, 0, 4'd3, 32'd5), mk(1, 0, 0, 0, 4'd3, 32'd7), '0);
        bus_a.in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_a.in_valid = 1'b0;
        checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid out_valid=%b err=%b need 0 0", bus_a.out_valid, bus_a.err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_a.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_discard out_valid=%b need 0", bus_a.out_valid);
        end
    endtask

    task automatic test_dest_keep();
        bus_a_t expv = pk4('0, mk(1, 1, 0, 0, 4'd5, 32'd30), '0, '0);
        drive_a(pk4(mk(1, 0, 0, 0, 4'd5, 32'd10), mk(1, 1, 0, 0, 4'd0, 32'd99), mk(1, 0, 0, 0, 4'd5, 32'd20), '0));
        checks++;
        if (bus_a.err !== 1'b1 || bus_a.out !== expv) begin
            errors++;
            $display("FAIL dest_keep err=%b got=%h need=%h", bus_a.err, bus_a.out, expv);
        end
        do_reset();
    endtask

`ifdef FAN_NODE_STATS_EN
    task automatic test_stats();
        do_reset();
        drive_a(pk4('0, mk(1, 0, 0, 0, 4'd3, 32'd5), mk(1, 0, 0, 0, 4'd3, 32'd7), '0));
        drive_a(pk4('0, mk(1, 0, 0, 0, 4'd3, 32'd5), mk(1, 0, 0, 0, 4'd4, 32'd7), '0));
        drive_a(pk4('0, mk(1, 0, 1, 0, 4'd2, 32'd1), mk(1, 0, 0, 0, 4'd2, 32'd1), '0));
        drive_a(pk4('0, mk(1, 0, 0, 0, 4'd6, 32'd1), mk(1, 0, 0, 1, 4'd6, 32'd2), '0));
        drive_a(pk4('0, '0, mk(1, 0, 0, 0, 4'd6, 32'd2), '0));
        checks++;
        if (bus_a.beat_cnt !== 16'd5 || bus_a.merge_cnt !== 16'd3) begin
            errors++;
            $display("FAIL stats beat_cnt=%0d merge_cnt=%0d need 5 3", bus_a.beat_cnt, bus_a.merge_cnt);
        end
    endtask
`endif

    task automatic test_latency_b();
        bus_b_t expv = exp_b(0);
        bus_b.in = beat_b(0);
        bus_b.in_valid = 1'b1;
        bus_b.out_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            bus_b.in_valid = 1'b0;
            checks++;
            if (bus_b.out_valid !== (c == 3)) begin
                errors++;
                $display("FAIL latency cycle=%0d out_valid=%b need %b", c, bus_b.out_valid, (c == 3));
            end
            if (c == 3) begin
                checks++;
                if (bus_b.out !== expv) begin
                    errors++;
                    $display("FAIL latency_data l3=%h need %h", bus_b.out[3*DW_LINE +: DW_LINE], expv[3*DW_LINE +: DW_LINE]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   tx = 0;
        int   rx = 0;
        int   held = 0;
        logic acc_in, acc_out;
        bus_b_t expv;
        for (int c = 0; c < 200 && rx < 10; c++) begin
            bus_b.out_ready = pat[c % 4];
            bus_b.in_valid  = (tx < 10);
            bus_b.in        = beat_b(tx);
            #1;
            acc_in  = bus_b.in_valid & bus_b.in_ready;
            acc_out = bus_b.out_valid & bus_b.out_ready;
            if (bus_b.out_valid && !bus_b.out_ready) begin
                held++;
                checks++;
                if (bus_b.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_in_ready cycle=%0d in_ready=%b need 0", c, bus_b.in_ready);
                end
            end
            if (acc_out) begin
                expv = exp_b(rx);
                checks++;
                if (bus_b.out !== expv) begin
                    errors++;
                    $display("FAIL bp_beat rx=%0d l0=%h l3=%h l4=%h need l0=%h l3=%h l4=%h", rx,
                             bus_b.out[0 +: DW_LINE], bus_b.out[3*DW_LINE +: DW_LINE], bus_b.out[4*DW_LINE +: DW_LINE],
                             expv[0 +: DW_LINE], expv[3*DW_LINE +: DW_LINE], expv[4*DW_LINE +: DW_LINE]);
                end
            end
            @(posedge clk);
            #1;
            if (acc_in) tx++;
            if (acc_out) rx++;
        end
        bus_b.in_valid = 1'b0;
        checks++;
        if (rx != 10 || tx != 10) begin
            errors++;
            $display("FAIL bp_count rx=%0d tx=%0d need 10 10", rx, tx);
        end
        checks++;
        if (held == 0) begin
            errors++;
            $display("FAIL bp_held held=%0d need >0", held);
        end
        checks++;
        if (bus_b.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained out_valid=%b need 0", bus_b.out_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_a.in = '0;
        bus_a.in_valid = 1'b0;
        bus_a.out_ready = 1'b1;
        bus_b.in = '0;
        bus_b.in_valid = 1'b0;
        bus_b.out_ready = 1'b1;
        test_reset();
        test_merge();
        test_mismatch();
        test_wrap_cont();
        test_cont_right();
        test_error_reset();
        test_dest_keep();
`ifdef FAN_NODE_STATS_EN
        test_stats();
`endif
        test_latency_b();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
